// File: rtl/power_sequencer.sv
// ============================================================================
// power_sequencer : FPGA rail power-up/down sequencer with fault shutdown
// Rev 1.0
// ============================================================================
`default_nettype none

module power_sequencer #(
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          cmd_on,
   input  logic          cmd_off,
   input  logic          clr_fault,
   input  logic          fault,
   input  logic [TW-1:0] settle_cyc,
   output logic          off_vcore_fpga,
   output logic          off_vdigital_fpga,
   output logic          functional,
   output logic [3:0]    state,
   output logic          busy,
   output logic          pwr_good
);

   typedef enum logic [3:0] {
      OFF      = 4'd0,
      UP_VCORE = 4'd1,
      UP_VDIG  = 4'd2,
      UP_FUNC  = 4'd3,
      ON       = 4'd4,
      DN_FUNC  = 4'd5,
      DN_VDIG  = 4'd6,
      DN_VCORE = 4'd7,
      FAULT    = 4'd8
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          fault_meta_q, fault_s_q;
   logic          vcore_off_q, vcore_off_d;
   logic          vdig_off_q, vdig_off_d;
   logic          func_q, func_d;
   logic          busy_q, busy_d;
   logic          pwr_good_q, pwr_good_d;
   logic          expired;
   logic [TW-1:0] load_val;

   assign expired  = (timer_q <= TW'(1));
   assign load_val = (settle_cyc == '0) ? TW'(1) : settle_cyc;

   always_comb begin
      state_d = state_q;
      timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;

      if (fault_s_q && state_q != FAULT) begin
         state_d = FAULT;
         timer_d = '0;
      end else begin
         case (state_q)
            OFF: begin
               // cmd_off wins a tie with cmd_on, and OFF has nothing to do for it
               if (cmd_on && !cmd_off) begin
                  state_d = UP_VCORE;
                  timer_d = load_val;
               end
            end
            UP_VCORE: begin
               if (cmd_off) begin
                  state_d = DN_VDIG;
                  timer_d = load_val;
               end else if (expired) begin
                  state_d = UP_VDIG;
                  timer_d = load_val;
               end
            end
            UP_VDIG, UP_FUNC, ON: begin
               if (cmd_off) begin
                  state_d = DN_FUNC;
                  timer_d = load_val;
               end else if (state_q == UP_VDIG && expired) begin
                  state_d = UP_FUNC;
                  timer_d = load_val;
               end else if (state_q == UP_FUNC && expired) begin
                  state_d = ON;
                  timer_d = '0;
               end
            end
            DN_FUNC: begin
               if (expired) begin
                  state_d = DN_VDIG;
                  timer_d = load_val;
               end
            end
            DN_VDIG: begin
               if (expired) begin
                  state_d = DN_VCORE;
                  timer_d = load_val;
               end
            end
            DN_VCORE: begin
               if (expired) begin
                  state_d = OFF;
                  timer_d = '0;
               end
            end
            FAULT: begin
               if (clr_fault && !fault_s_q) state_d = OFF;
            end
            default: begin
               state_d = FAULT;
               timer_d = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they update on the same edge as state_q
   always_comb begin
      vcore_off_d = 1'b1;
      vdig_off_d  = 1'b1;
      func_d      = 1'b0;
      busy_d      = 1'b0;
      pwr_good_d  = 1'b0;
      case (state_d)
         UP_VCORE: begin vcore_off_d = 1'b0; busy_d = 1'b1; end
         UP_VDIG:  begin vcore_off_d = 1'b0; vdig_off_d = 1'b0; busy_d = 1'b1; end
         UP_FUNC:  begin vcore_off_d = 1'b0; vdig_off_d = 1'b0; func_d = 1'b1; busy_d = 1'b1; end
         ON:       begin vcore_off_d = 1'b0; vdig_off_d = 1'b0; func_d = 1'b1; pwr_good_d = 1'b1; end
         DN_FUNC:  begin vcore_off_d = 1'b0; vdig_off_d = 1'b0; busy_d = 1'b1; end
         DN_VDIG:  begin vcore_off_d = 1'b0; busy_d = 1'b1; end
         DN_VCORE: busy_d = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= OFF;
         timer_q      <= '0;
         fault_meta_q <= 1'b0;
         fault_s_q    <= 1'b0;
         vcore_off_q  <= 1'b1;
         vdig_off_q   <= 1'b1;
         func_q       <= 1'b0;
         busy_q       <= 1'b0;
         pwr_good_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         fault_meta_q <= fault;
         fault_s_q    <= fault_meta_q;
         vcore_off_q  <= vcore_off_d;
         vdig_off_q   <= vdig_off_d;
         func_q       <= func_d;
         busy_q       <= busy_d;
         pwr_good_q   <= pwr_good_d;
      end
   end

   assign state             = state_q;
   assign off_vcore_fpga    = vcore_off_q;
   assign off_vdigital_fpga = vdig_off_q;
   assign functional        = func_q;
   assign busy              = busy_q;
   assign pwr_good          = pwr_good_q;

endmodule

`default_nettype wire

// File: tb/tb_power_sequencer.sv
// ============================================================================
// tb_power_sequencer : directed checks of sequencing, abort, fault and reset
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_power_sequencer;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        cmd_on, cmd_off, clr_fault, fault;
   logic [15:0] settle_cyc;
   logic        off_vcore_fpga, off_vdigital_fpga, functional, busy, pwr_good;
   logic [3:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   power_sequencer #(.TW(16)) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .cmd_on            (cmd_on),
      .cmd_off           (cmd_off),
      .clr_fault         (clr_fault),
      .fault             (fault),
      .settle_cyc        (settle_cyc),
      .off_vcore_fpga    (off_vcore_fpga),
      .off_vdigital_fpga (off_vdigital_fpga),
      .functional        (functional),
      .state             (state),
      .busy              (busy),
      .pwr_good          (pwr_good)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected fields: state, off_vcore, off_vdig, functional, busy, pwr_good
   task automatic chk(input string tag, input logic [3:0] st, input logic vc,
                      input logic vd, input logic fn, input logic bz, input logic pg);
      logic [8:0] obs, exp;
      obs = {state, off_vcore_fpga, off_vdigital_fpga, functional, busy, pwr_good};
      exp = {st, vc, vd, fn, bz, pg};
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (state,vc_off,vd_off,func,busy,pg)",
                tag, obs, exp);
      end
   endtask

   initial begin
      n_rst = 1'b0; cmd_on = 1'b0; cmd_off = 1'b0; clr_fault = 1'b0;
      fault = 1'b0; settle_cyc = 16'd10;
      #12;
      chk("reset_values", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_rst = 1'b1;
      tick(5);
      chk("idle_after_reset", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Power-up, settle 10; settle_cyc briefly changed mid-wait
      cmd_on = 1'b1; tick(1); cmd_on = 1'b0;
      chk("up_vcore_N+1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      settle_cyc = 16'd3;
      tick(5);
      settle_cyc = 16'd10;
      tick(4);
      chk("up_vcore_N+10", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk("up_vdig_N+11", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(9);
      chk("up_vdig_N+20", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk("up_func_N+21", 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(9);
      chk("up_func_N+30", 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(1);
      chk("on_N+31", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cmd_on = 1'b1; tick(1); cmd_on = 1'b0;
      chk("cmd_on_ignored_in_on", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Power-down, settle 4
      settle_cyc = 16'd4;
      cmd_off = 1'b1; tick(1); cmd_off = 1'b0;
      chk("dn_func_M+1", 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(4);
      chk("dn_vdig_M+5", 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(4);
      chk("dn_vcore_M+9", 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(3);
      chk("dn_vcore_M+12", 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk("off_M+13", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Simultaneous on+off in OFF
      cmd_on = 1'b1; cmd_off = 1'b1; tick(1); cmd_on = 1'b0; cmd_off = 1'b0;
      chk("on_off_tie", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(2);
      chk("on_off_tie_hold", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Abort from UP_VCORE, settle 10
      settle_cyc = 16'd10;
      cmd_on = 1'b1; tick(1); cmd_on = 1'b0;
      tick(2);
      chk("abort_pre", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cmd_off = 1'b1; tick(1); cmd_off = 1'b0;
      chk("abort_dn_vdig", 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(9);
      chk("abort_dn_vdig_end", 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk("abort_dn_vcore", 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(9);
      chk("abort_dn_vcore_end", 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk("abort_off", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // settle_cyc = 0 acts as one cycle per step
      settle_cyc = 16'd0;
      cmd_on = 1'b1; tick(1); cmd_on = 1'b0;
      chk("s0_up_vcore", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk("s0_up_vdig", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk("s0_up_func", 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(1);
      chk("s0_on", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Fault while ON
      fault = 1'b1;
      tick(2);
      chk("fault_sync_delay", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1);
      chk("fault_3rd_edge", 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
      chk("clr_with_fault_high", 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      fault = 1'b0;
      tick(2);
      chk("fault_low_no_clr", 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
      chk("clr_fault_exit", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(3);
      chk("no_auto_restart", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in UP_FUNC
      settle_cyc = 16'd10;
      cmd_on = 1'b1; tick(1); cmd_on = 1'b0;
      tick(20);
      chk("pre_reset_up_func", 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #2 n_rst = 1'b0;
      #1;
      chk("async_reset", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 n_rst = 1'b1;
      tick(3);
      chk("post_reset_idle", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
